mem_fifo_ctrl: RTL and testbench
================================

Name: mem_fifo_ctrl

Overview:
- Control stage directly upstream of the 8-bit, 8-address register-file memory; owns its write/read ports and addresses.
- Turns the memory into a circular FIFO of DEPTH=7 entries. Address 7 is invalid on the memory and is never issued.
- Producer side is a push interface; consumer side is a pop request with 1-cycle-latency data return.

Parameters:
- DW, 8, data width; matches memory datain/dataout.
- AW, 3, address width; matches memory addr_w/addr_r.
- DEPTH, 7, usable entries (addresses 0..DEPTH-1); must be ≤ 2**AW-1.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push  in  1  producer write request.
- push_data  in  DW  data to enqueue.
- full  out  1  count == DEPTH.
- pop  in  1  consumer read request.
- pop_data  out  DW  dequeued data; equals mem_dataout, valid only when pop_valid=1.
- pop_valid  out  1  high the cycle after an accepted pop.
- empty  out  1  count == 0.
- count  out  AW  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: push attempted while full.
- unf  out  1  sticky: pop attempted while empty.
- mem_write  out  1  to memory write.
- mem_read  out  1  to memory read.
- mem_addr_w  out  AW  to memory addr_w.
- mem_addr_r  out  AW  to memory addr_r.
- mem_datain  out  DW  to memory datain.
- mem_dataout  in  DW  from memory dataout.

Behaviour:
- Memory contract:
  - Write at rising edge when mem_write=1.
  - Read is registered: mem_dataout = mem[addr_r] after the rising edge where mem_read=1.
- Reset (async, reset_n=0):
  - wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, ovf=0, unf=0.
  - Hence empty=1, full=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries; an in-flight pop_valid is dropped.
- Accept conditions (combinational):
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Flags are taken from the current cycle's count only. Push while full is rejected even with a simultaneous pop; pop while empty is rejected even with a simultaneous push. No bypass.
- Memory drive (combinational):
  - mem_write = push_acc; mem_addr_w = wr_ptr; mem_datain = push_data.
  - mem_read = pop_acc; mem_addr_r = rd_ptr.
- Pointers:
  - On acceptance, a pointer increments.
  - Wrap: DEPTH-1 → 0, never to address 7.
- Count (next value):
  - push_acc only: +1.
  - pop_acc only: -1.
  - Both, or neither: unchanged.
- Pop latency: pop_valid <= pop_acc (one cycle). pop_data is mem_dataout passthrough.
  - Back-to-back pops give pop_valid high on consecutive cycles.
- Read/write hazard: the same address is never written and read in the same cycle, because a read requires count≥1 and the write pointer then points at a free slot.
- Error flags:
  - ovf sets on push & full; unf sets on pop & empty.
  - Both clear only on reset.
  - Rejected requests do not change pointers, count or memory.
- States: implicit in count (EMPTY=0, PARTIAL, FULL=DEPTH). No other FSM.

Optional Feature:
- Macro: MEM_FIFO_DROP_CNT_EN.
- Defined:
  - Extra output drop_cnt [7:0], reset 0.
  - Increments on every rejected push or pop (+2 if both are rejected in one cycle).
  - Saturates at 8'hFF.
- Undefined: port absent, no logic; ovf/unf are unaffected either way.

Decomposition:
- Shared package mem_fifo_pkg holds:
  - constants DW=8, AW=3, DEPTH=7, MEM_INVALID_ADDR=3'd7;
  - typedef data_t (logic [DW-1:0]);
  - typedef addr_t (logic [AW-1:0]).
- Natural sub-module: mem_fifo_ptr. It is a wrapping pointer counter with an increment enable and wrap at DEPTH-1, instantiated twice (wr/rd).
- The count and flag logic stays in the top.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, pop_valid=0, mem_write=0, mem_read=0.
- Push 8'h05, 8'h08, 8'h10 on consecutive cycles → mem_addr_w 0, 1, 2; count=3. Pop ×3 → pop_valid on cycles +1..+3 with pop_data 05, 08, 10; empty=1.
- Push 7 values 8'h40..8'h46 → full=1, count=7, no mem_addr_w=7 issued. 8th push 8'h70 → rejected, ovf=1, count stays 7.
- Fill to 5, then assert push=1 (8'hAA) and pop=1 together for 4 cycles → count stays 5. Pointers wrap 6→0; popped data is in FIFO order.
- Pop while empty → mem_read=0, pop_valid=0, unf=1. With MEM_FIFO_DROP_CNT_EN: drop_cnt=1; after test 3's overflow as well: 2.
- Assert reset_n=0 asynchronously mid-burst with count=4 and pop_valid=1 → all outputs take reset values immediately. After release, a push of 8'h04 goes to address 0.

Source files
------------

// File: rtl/mem_fifo_pkg.sv
// Shared constants and types for the 7-entry FIFO controller that fronts the 8x8 register file.
// Optional build macro used by this slice: MEM_FIFO_DROP_CNT_EN.
package mem_fifo_pkg;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 7;

    // Address 7 does not exist on the memory, so the pointers wrap before reaching it.
    localparam logic [AW-1:0] MEM_INVALID_ADDR = 3'd7;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/mem_fifo_ptr.sv
// Wrapping FIFO pointer: advances on inc and wraps from DEPTH-1 back to 0.
// Used twice by mem_fifo_ctrl, once for the write side and once for the read side.
module mem_fifo_ptr
    import mem_fifo_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  inc,
    output addr_t ptr
);

    addr_t r_ptr;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == addr_t'(DEPTH - 1)) ? '0 : r_ptr + addr_t'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Circular-FIFO controller that owns the register-file ports; occupancy lives in count.
// Build macro MEM_FIFO_DROP_CNT_EN adds a saturating drop_cnt output for rejected requests.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  data_t      push_data,
    output logic       full,
    input  logic       pop,
    output data_t      pop_data,
    output logic       pop_valid,
    output logic       empty,
    output addr_t      count,
    output logic       ovf,
    output logic       unf,
    output logic       mem_write,
    output logic       mem_read,
    output addr_t      mem_addr_w,
    output addr_t      mem_addr_r,
    output data_t      mem_datain,
    input  data_t      mem_dataout
`ifdef MEM_FIFO_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    addr_t r_count;
    logic  r_pop_valid;
    logic  r_ovf;
    logic  r_unf;

    logic  w_full;
    logic  w_empty;
    logic  w_push_acc;
    logic  w_pop_acc;
    logic  w_push_rej;
    logic  w_pop_rej;
    addr_t w_wr_ptr;
    addr_t w_rd_ptr;

    // Acceptance looks only at this cycle's count: no bypass between push and pop.
    assign w_full     = (r_count == addr_t'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push & ~w_full;
    assign w_pop_acc  = pop & ~w_empty;
    assign w_push_rej = push & w_full;
    assign w_pop_rej  = pop & w_empty;

    mem_fifo_ptr u_wr_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_push_acc),
        .ptr     (w_wr_ptr)
    );

    mem_fifo_ptr u_rd_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_pop_acc),
        .ptr     (w_rd_ptr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + addr_t'(1);
                2'b01:   r_count <= r_count - addr_t'(1);
                default: r_count <= r_count;
            endcase
            r_pop_valid <= w_pop_acc;
            r_ovf       <= r_ovf | w_push_rej;
            r_unf       <= r_unf | w_pop_rej;
        end
    end

`ifdef MEM_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    assign w_drop_inc = {1'b0, w_push_rej} + {1'b0, w_pop_rej};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_inc};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign mem_write  = w_push_acc;
    assign mem_addr_w = w_wr_ptr;
    assign mem_datain = push_data;
    assign mem_read   = w_pop_acc;
    assign mem_addr_r = w_rd_ptr;

    assign pop_data   = mem_dataout;
    assign pop_valid  = r_pop_valid;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf        = r_ovf;
    assign unf        = r_unf;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: a register-file model on the memory ports and a queue-based FIFO reference.
// Build with MEM_FIFO_DROP_CNT_EN defined to also cover drop_cnt.
module tb_mem_fifo_ctrl;
    import mem_fifo_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       push;
    data_t      push_data;
    logic       full;
    logic       pop;
    data_t      pop_data;
    logic       pop_valid;
    logic       empty;
    addr_t      count;
    logic       ovf;
    logic       unf;
    logic       mem_write;
    logic       mem_read;
    addr_t      mem_addr_w;
    addr_t      mem_addr_r;
    data_t      mem_datain;
    data_t      mem_dataout;
`ifdef MEM_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    mem_fifo_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .empty       (empty),
        .count       (count),
        .ovf         (ovf),
        .unf         (unf),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_addr_w  (mem_addr_w),
        .mem_addr_r  (mem_addr_r),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
`ifdef MEM_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model: synchronous write, registered read, contents never cleared.
    data_t mem [8];
    always @(posedge clock) begin
        if (mem_write) mem[mem_addr_w] <= mem_datain;
        if (mem_read)  mem_dataout     <= mem[mem_addr_r];
    end

    // Protocol watchers: illegal address 7 or a same-address write/read pair.
    bit bad_addr_seen;
    bit hazard_seen;
    always @(posedge clock) begin
        if ((mem_write && mem_addr_w == MEM_INVALID_ADDR) || (mem_read && mem_addr_r == MEM_INVALID_ADDR))
            bad_addr_seen = 1'b1;
        if (mem_write && mem_read && mem_addr_w == mem_addr_r)
            hazard_seen = 1'b1;
    end

    // Reference model: FIFO contents as a queue, slot numbers from accepted-transfer totals.
    data_t q[$];
    int    n_pushed;
    int    n_popped;
    bit    ovf_m;
    bit    unf_m;
    int    drop_m;
    bit    exp_valid;
    data_t exp_data;

    int n_checks;
    int n_fail;

    task automatic model_reset();
        q.delete();
        n_pushed  = 0;
        n_popped  = 0;
        ovf_m     = 1'b0;
        unf_m     = 1'b0;
        drop_m    = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    // One clock of stimulus: checks the combinational memory drive, then the post-edge state.
    task automatic do_cycle(input bit p, input data_t d, input bit o);
        bit       full_m;
        bit       empty_m;
        bit       pa;
        bit       oa;
        bit [7:0] exp_stat;
        bit [7:0] got_stat;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        pa      = p && !full_m;
        oa      = o && !empty_m;
        push      = p;
        push_data = d;
        pop       = o;
        #1;
        n_checks++;
        if ({mem_write, mem_read} !== {pa, oa}) begin
            n_fail++;
            $display("FAIL mem_wr_rd: got %b%b expected %b%b", mem_write, mem_read, pa, oa);
        end
        if (pa) begin
            n_checks++;
            if ({mem_addr_w, mem_datain} !== {addr_t'(n_pushed % DEPTH), d}) begin
                n_fail++;
                $display("FAIL mem_write_port: got addr %0d data %h expected addr %0d data %h",
                         mem_addr_w, mem_datain, n_pushed % DEPTH, d);
            end
        end
        if (oa) begin
            n_checks++;
            if (mem_addr_r !== addr_t'(n_popped % DEPTH)) begin
                n_fail++;
                $display("FAIL mem_addr_r: got %0d expected %0d", mem_addr_r, n_popped % DEPTH);
            end
        end
        @(posedge clock);
        if (oa) begin
            exp_data = q.pop_front();
            n_popped++;
        end
        if (pa) begin
            q.push_back(d);
            n_pushed++;
        end
        exp_valid = oa;
        ovf_m     = ovf_m | (p && full_m);
        unf_m     = unf_m | (o && empty_m);
        drop_m    = drop_m + int'(p && full_m) + int'(o && empty_m);
        if (drop_m > 255) drop_m = 255;
        #1;
        exp_stat = {3'(q.size()), q.size() == 0, q.size() == DEPTH, ovf_m, unf_m, exp_valid};
        got_stat = {count, empty, full, ovf, unf, pop_valid};
        n_checks++;
        if (got_stat !== exp_stat) begin
            n_fail++;
            $display("FAIL status{count,empty,full,ovf,unf,pop_valid}: got %b expected %b", got_stat, exp_stat);
        end
        if (exp_valid) begin
            n_checks++;
            if (pop_data !== exp_data) begin
                n_fail++;
                $display("FAIL pop_data: got %h expected %h", pop_data, exp_data);
            end
        end
`ifdef MEM_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'(drop_m)) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, drop_m);
        end
`endif
    endtask

    task automatic test_reset();
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        reset_n   = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({count, empty, full, pop_valid, mem_write, mem_read, ovf, unf} !== {3'd0, 1'b1, 1'b0, 5'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d empty=%b full=%b pv=%b mw=%b mr=%b ovf=%b unf=%b expected 0 1 0 0 0 0 0 0",
                     count, empty, full, pop_valid, mem_write, mem_read, ovf, unf);
        end
        #16 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_basic();
        do_cycle(1'b1, 8'h05, 1'b0);
        do_cycle(1'b1, 8'h08, 1'b0);
        do_cycle(1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, data_t'(8'h40 + i), 1'b0);
        do_cycle(1'b1, 8'h70, 1'b0);
        do_cycle(1'b1, 8'h71, 1'b1);
        n_checks++;
        if (bad_addr_seen) begin
            n_fail++;
            $display("FAIL addr7_issued: got 1 expected 0");
        end
    endtask

    task automatic test_simultaneous();
        while (q.size() > 5) do_cycle(1'b0, '0, 1'b1);
        while (q.size() < 5) do_cycle(1'b1, data_t'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'hAA, 1'b1);
        while (q.size() > 0) do_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_underflow();
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b1, 8'h3C, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, data_t'(8'h20 + i), 1'b0);
        do_cycle(1'b1, 8'h24, 1'b1);
        push = 1'b0;
        pop  = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({count, empty, full, pop_valid, mem_write, mem_read, ovf, unf} !== {3'd0, 1'b1, 1'b0, 5'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d empty=%b full=%b pv=%b mw=%b mr=%b ovf=%b unf=%b expected 0 1 0 0 0 0 0 0",
                     count, empty, full, pop_valid, mem_write, mem_read, ovf, unf);
        end
        #13 reset_n = 1'b1;
        do_cycle(1'b1, 8'h04, 1'b0);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 9) < 6, data_t'($urandom), $urandom_range(0, 9) < 5);
        end
        n_checks++;
        if ({bad_addr_seen, hazard_seen} !== 2'b00) begin
            n_fail++;
            $display("FAIL mem_protocol{addr7,hazard}: got %b expected 00", {bad_addr_seen, hazard_seen});
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bad_addr_seen = 1'b0;
        hazard_seen   = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_underflow();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
